// File: rtl/vga_sync_generator_pkg.sv
// Shared VGA timing defaults (640x480@60), vertical-phase encoding and raster payload type.
// Optional VGA_FRAME_COUNT_EN adds the frame counter width.
package vga_sync_generator_pkg;

   localparam int unsigned CNT_W = 10;

`ifdef VGA_FRAME_COUNT_EN
   localparam int unsigned FRAME_W = 16;
`endif

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_TOTAL  = 800;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_TOTAL  = 525;

   typedef enum logic [1:0] {
      VS_ACTIVE = 2'd0,
      VS_FRONT  = 2'd1,
      VS_SYNC   = 2'd2,
      VS_BACK   = 2'd3
   } vs_state_t;

   typedef struct packed {
      logic             hsync;
      logic             vsync;
      logic             video_on;
      logic [CNT_W-1:0] pixel_x;
      logic [CNT_W-1:0] pixel_y;
   } raster_t;

   // Half-open window test lo <= value < hi on counter-width operands.
   function automatic logic in_window(input logic [CNT_W-1:0] value,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (value >= lo) && (value < hi);
   endfunction

endpackage

// File: rtl/vga_sync_generator_if.sv
// Raster bus between the horizontal counter / pixel pipeline (master) and the sync generator (slave).
// frame_count exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_sync_generator_if;
   import vga_sync_generator_pkg::*;

   logic [CNT_W-1:0] H_count_value;
   logic             enable_V_counter;
   logic [CNT_W-1:0] V_count_value;
   logic             hsync;
   logic             vsync;
   logic             video_on;
   logic [CNT_W-1:0] pixel_x;
   logic [CNT_W-1:0] pixel_y;
   logic             frame_start;

`ifdef VGA_FRAME_COUNT_EN
   logic [FRAME_W-1:0] frame_count;

   modport master (
      output H_count_value, enable_V_counter,
      input  V_count_value, hsync, vsync, video_on, pixel_x, pixel_y, frame_start, frame_count
   );

   modport slave (
      input  H_count_value, enable_V_counter,
      output V_count_value, hsync, vsync, video_on, pixel_x, pixel_y, frame_start, frame_count
   );
`else
   modport master (
      output H_count_value, enable_V_counter,
      input  V_count_value, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
   );

   modport slave (
      input  H_count_value, enable_V_counter,
      output V_count_value, hsync, vsync, video_on, pixel_x, pixel_y, frame_start
   );
`endif

endinterface

// File: rtl/vga_sync_generator_vertical_counter.sv
// Line counter, vertical-phase FSM and frame_start pulse; advances only on the line strobe.
// With VGA_FRAME_COUNT_EN it also counts frame wraps.
module vga_sync_generator_vertical_counter
   import vga_sync_generator_pkg::*;
#(
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_TOTAL  = DEF_V_TOTAL
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   output logic [CNT_W-1:0]   v_count,
   output vs_state_t          state,
`ifdef VGA_FRAME_COUNT_EN
   output logic [FRAME_W-1:0] frame_count,
`endif
   output logic               frame_start
);

   localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic             wrap_c;
   logic [CNT_W-1:0] v_next_c;

   always_comb begin
      wrap_c   = enable && (v_count == V_LAST);
      v_next_c = (v_count == V_LAST) ? '0 : v_count + CNT_W'(1);
   end

   // Phase transitions are decided on the line number being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_count     <= '0;
         state       <= VS_ACTIVE;
         frame_start <= 1'b0;
`ifdef VGA_FRAME_COUNT_EN
         frame_count <= '0;
`endif
      end else begin
         frame_start <= wrap_c;
         if (enable) begin
            v_count <= v_next_c;
            case (state)
               VS_ACTIVE: if (v_next_c == FRONT_START) state <= VS_FRONT;
               VS_FRONT:  if (v_next_c == SYNC_START)  state <= VS_SYNC;
               VS_SYNC:   if (v_next_c == BACK_START)  state <= VS_BACK;
               VS_BACK:   if (v_next_c == '0)          state <= VS_ACTIVE;
               default:   state <= VS_ACTIVE;
            endcase
         end
`ifdef VGA_FRAME_COUNT_EN
         if (wrap_c) frame_count <= frame_count + FRAME_W'(1);
`endif
      end
   end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster closer: H decode plus registered sync/video/pixel outputs around the vertical counter.
// Define VGA_FRAME_COUNT_EN to add the 16-bit frame_count output.
module vga_sync_generator
   import vga_sync_generator_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
   parameter bit          SYNC_POL = 1'b0
) (
   input logic                 clk_25MHz,
   input logic                 reset_n,
   vga_sync_generator_if.slave bus
);

   localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] H_LIMIT   = CNT_W'(H_TOTAL);

   localparam raster_t RASTER_RST = '{
      hsync:    ~SYNC_POL,
      vsync:    ~SYNC_POL,
      video_on: 1'b0,
      pixel_x:  '0,
      pixel_y:  '0
   };

   logic [CNT_W-1:0] v_count;
   vs_state_t        v_state;
   logic             frame_start;
`ifdef VGA_FRAME_COUNT_EN
   logic [FRAME_W-1:0] frame_count;
`endif

   vga_sync_generator_vertical_counter #(
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_TOTAL  (V_TOTAL)
   ) u_vertical_counter (
      .clk         (clk_25MHz),
      .rst_n       (reset_n),
      .enable      (bus.enable_V_counter),
      .v_count     (v_count),
      .state       (v_state),
`ifdef VGA_FRAME_COUNT_EN
      .frame_count (frame_count),
`endif
      .frame_start (frame_start)
   );

   raster_t raster_c;
   raster_t raster_q;
   logic    h_legal_c;
   logic    video_c;

   // Out-of-range H positions are forced to blanking.
   always_comb begin
      raster_c          = RASTER_RST;
      h_legal_c         = bus.H_count_value < H_LIMIT;
      video_c           = h_legal_c && (bus.H_count_value < H_ACT_END) && (v_state == VS_ACTIVE);
      raster_c.video_on = video_c;
      raster_c.hsync    = (h_legal_c && in_window(bus.H_count_value, HS_START, HS_END))
                          ? SYNC_POL : ~SYNC_POL;
      raster_c.vsync    = (v_state == VS_SYNC) ? SYNC_POL : ~SYNC_POL;
      if (video_c) begin
         raster_c.pixel_x = bus.H_count_value;
         raster_c.pixel_y = v_count;
      end
   end

   always_ff @(posedge clk_25MHz or negedge reset_n) begin
      if (!reset_n) raster_q <= RASTER_RST;
      else          raster_q <= raster_c;
   end

   assign bus.V_count_value = v_count;
   assign bus.frame_start   = frame_start;
   assign bus.hsync         = raster_q.hsync;
   assign bus.vsync         = raster_q.vsync;
   assign bus.video_on      = raster_q.video_on;
   assign bus.pixel_x       = raster_q.pixel_x;
   assign bus.pixel_y       = raster_q.pixel_y;
`ifdef VGA_FRAME_COUNT_EN
   assign bus.frame_count   = frame_count;
`endif

endmodule
